// File: rtl/pll_lock_reset_seq.sv
// PLL lock monitor and system reset sequencer, clocked by the free-running PLL reference clock.
// Optional PLL restart on lock timeout is enabled by defining PLL_LOCK_RESTART_EN.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int LOSS_FILTER    = 4,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_i,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       pll_rst_o,
  output logic [7:0] loss_count_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    RESTART   = 2'd3
  } state_t;

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FILTER_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [FILTER_W-1:0] FILTER_LAST = FILTER_W'(LOSS_FILTER - 1);

`ifdef PLL_LOCK_RESTART_EN
  localparam int TIMEOUT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int PRST_W    = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT - 1);
  localparam logic [PRST_W-1:0]    PRST_LAST    = PRST_W'(PLL_RST_CYCLES - 1);

  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [PRST_W-1:0]    prst_q, prst_d;
  logic                 pll_rst_q, pll_rst_d;
`endif

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     locked_s;
  logic [SETTLE_W-1:0]      settle_q, settle_d;
  logic [FILTER_W-1:0]      filter_q, filter_d;
  logic [7:0]               loss_q, loss_d;
  logic                     sys_rst_q, sys_rst_d;
  logic                     ready_q, ready_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State, counters, synchronizer and registered outputs; rst aborts everything, including a restart pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      sync_q    <= '0;
      settle_q  <= '0;
      filter_q  <= '0;
      loss_q    <= '0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
`ifdef PLL_LOCK_RESTART_EN
      timeout_q <= '0;
      prst_q    <= '0;
      pll_rst_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], locked_i};
      settle_q  <= settle_d;
      filter_q  <= filter_d;
      loss_q    <= loss_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
`ifdef PLL_LOCK_RESTART_EN
      timeout_q <= timeout_d;
      prst_q    <= prst_d;
      pll_rst_q <= pll_rst_d;
`endif
    end
  end

  // Counters default to zero so every state is entered with fresh counts.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    filter_d = '0;
    loss_d   = loss_q;
`ifdef PLL_LOCK_RESTART_EN
    prst_d   = '0;
`endif
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = SETTLE;
`ifdef PLL_LOCK_RESTART_EN
        else if (timeout_q == TIMEOUT_LAST) state_d = RESTART;
`endif
      end
      SETTLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (settle_q == SETTLE_LAST) state_d = RUN;
        else settle_d = settle_q + SETTLE_W'(1);
      end
      RUN: begin
        if (!locked_s) begin
          if (filter_q == FILTER_LAST) begin
            state_d = WAIT_LOCK;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end else begin
            filter_d = filter_q + FILTER_W'(1);
          end
        end
      end
      RESTART: begin
`ifdef PLL_LOCK_RESTART_EN
        if (prst_q == PRST_LAST) state_d = WAIT_LOCK;
        else prst_d = prst_q + PRST_W'(1);
`else
        state_d = WAIT_LOCK;
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase
`ifdef PLL_LOCK_RESTART_EN
    // Only a stay in WAIT_LOCK accumulates timeout; any other path restarts the count.
    timeout_d = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? timeout_q + TIMEOUT_W'(1) : '0;
`endif
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
`ifdef PLL_LOCK_RESTART_EN
    pll_rst_d = (state_d == RESTART);
`endif
  end

  assign sys_rst_o    = sys_rst_q;
  assign ready_o      = ready_q;
  assign loss_count_o = loss_q;
  assign state_o      = state_q;
`ifdef PLL_LOCK_RESTART_EN
  assign pll_rst_o    = pll_rst_q;
`else
  assign pll_rst_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed self-checking bench for pll_lock_reset_seq with small test-plan parameters.
// Restart expectations follow PLL_LOCK_RESTART_EN, matching the design build.
module tb_pll_lock_reset_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked_i;
  logic       sys_rst_o;
  logic       ready_o;
  logic       pll_rst_o;
  logic [7:0] loss_count_o;
  logic [1:0] state_o;

  int tests = 0;
  int fails = 0;

  pll_lock_reset_seq #(
    .SYNC_STAGES(2),
    .SETTLE_CYCLES(8),
    .LOSS_FILTER(3),
    .LOCK_TIMEOUT(32),
    .PLL_RST_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked_i(locked_i),
    .sys_rst_o(sys_rst_o),
    .ready_o(ready_o),
    .pll_rst_o(pll_rst_o),
    .loss_count_o(loss_count_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    locked_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    locked_i = 1'b1;
    repeat (3) tick();
    tests++;
    if ({state_o, sys_rst_o, ready_o, pll_rst_o, loss_count_o} !== {2'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("[TB] FAIL reset_values: state=%0d sys_rst=%b ready=%b pll_rst=%b loss=%0d, required 0 1 0 0 0",
               state_o, sys_rst_o, ready_o, pll_rst_o, loss_count_o);
    end
    locked_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Lock rises at edge 0: SETTLE from edge 2, RUN and release at edge 10.
  task automatic test_release();
    logic [1:0] exp_state;
    apply_reset();
    locked_i = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp_state = (e < 2) ? 2'd0 : (e < 10) ? 2'd1 : 2'd2;
      tests++;
      if (state_o !== exp_state || sys_rst_o !== (e < 10) || ready_o !== (e >= 10)) begin
        fails++;
        $display("[TB] FAIL release_edge%0d: state=%0d sys_rst=%b ready=%b, required state=%0d sys_rst=%b ready=%b",
                 e, state_o, sys_rst_o, ready_o, exp_state, (e < 10), (e >= 10));
      end
    end
  endtask

  // Lock high on edges 0..4 then low: SETTLE still at edge 6, back to WAIT_LOCK at edge 7.
  task automatic test_settle_abort();
    logic [1:0] exp_state;
    apply_reset();
    locked_i = 1'b1;
    repeat (5) tick();
    locked_i = 1'b0;
    for (int e = 5; e <= 12; e++) begin
      tick();
      exp_state = (e < 7) ? 2'd1 : 2'd0;
      tests++;
      if (state_o !== exp_state || sys_rst_o !== 1'b1 || loss_count_o !== 8'd0) begin
        fails++;
        $display("[TB] FAIL settle_abort_edge%0d: state=%0d sys_rst=%b loss=%0d, required state=%0d sys_rst=1 loss=0",
                 e, state_o, sys_rst_o, loss_count_o, exp_state);
      end
    end
  endtask

  task automatic test_glitch_and_loss();
    logic glitch_ok;
    apply_reset();
    locked_i = 1'b1;
    repeat (11) tick();
    locked_i = 1'b0;
    repeat (2) tick();
    locked_i = 1'b1;
    glitch_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (state_o !== 2'd2 || sys_rst_o !== 1'b0) glitch_ok = 1'b0;
    end
    tests++;
    if (!glitch_ok) begin
      fails++;
      $display("[TB] FAIL glitch_reject: left RUN, state=%0d sys_rst=%b, required state=2 sys_rst=0", state_o, sys_rst_o);
    end
    locked_i = 1'b0;
    repeat (4) tick();
    tests++;
    if (sys_rst_o !== 1'b0 || state_o !== 2'd2) begin
      fails++;
      $display("[TB] FAIL loss_early: edge m+3 state=%0d sys_rst=%b, required state=2 sys_rst=0", state_o, sys_rst_o);
    end
    tick();
    tests++;
    if (sys_rst_o !== 1'b1 || ready_o !== 1'b0 || state_o !== 2'd0 || loss_count_o !== 8'd1) begin
      fails++;
      $display("[TB] FAIL loss_detect: state=%0d sys_rst=%b ready=%b loss=%0d, required 0 1 0 1",
               state_o, sys_rst_o, ready_o, loss_count_o);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_loss;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      locked_i = 1'b1;
      repeat (11) tick();
      tests++;
      if (state_o !== 2'd2) begin
        fails++;
        $display("[TB] FAIL sat_relock_%0d: state=%0d, required 2", i, state_o);
      end
      locked_i = 1'b0;
      repeat (5) tick();
      exp_loss = (i >= 254) ? 8'd255 : 8'(i + 1);
      tests++;
      if (loss_count_o !== exp_loss) begin
        fails++;
        $display("[TB] FAIL sat_loss_%0d: loss=%0d, required %0d", i, loss_count_o, exp_loss);
      end
    end
  endtask

  // Continues from the last loss edge of test_saturation (WAIT_LOCK, timeout cleared, lock low).
  task automatic test_restart();
`ifdef PLL_LOCK_RESTART_EN
    for (int r = 0; r < 2; r++) begin
      repeat (31) tick();
      tests++;
      if (state_o !== 2'd0 || pll_rst_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL restart_wait_%0d: state=%0d pll_rst=%b, required 0 0", r, state_o, pll_rst_o);
      end
      tick();
      tests++;
      if (state_o !== 2'd3 || pll_rst_o !== 1'b1 || sys_rst_o !== 1'b1 || loss_count_o !== 8'd255) begin
        fails++;
        $display("[TB] FAIL restart_enter_%0d: state=%0d pll_rst=%b sys_rst=%b loss=%0d, required 3 1 1 255",
                 r, state_o, pll_rst_o, sys_rst_o, loss_count_o);
      end
      if (r == 0) begin
        for (int c = 1; c < 4; c++) begin
          tick();
          tests++;
          if (pll_rst_o !== 1'b1 || state_o !== 2'd3) begin
            fails++;
            $display("[TB] FAIL restart_pulse_cycle%0d: pll_rst=%b state=%0d, required 1 3", c, pll_rst_o, state_o);
          end
        end
        tick();
        tests++;
        if (pll_rst_o !== 1'b0 || state_o !== 2'd0) begin
          fails++;
          $display("[TB] FAIL restart_exit: pll_rst=%b state=%0d, required 0 0", pll_rst_o, state_o);
        end
      end
    end
    tick();
    tests++;
    if (pll_rst_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL restart_cycle2: pll_rst=%b, required 1", pll_rst_o);
    end
`else
    logic quiet;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pll_rst_o !== 1'b0 || state_o !== 2'd0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("[TB] FAIL no_restart: pll_rst=%b state=%0d, required 0 0", pll_rst_o, state_o);
    end
`endif
  endtask

  task automatic test_reset_abort();
    rst = 1'b1;
    tick();
    tests++;
    if (pll_rst_o !== 1'b0 || state_o !== 2'd0 || sys_rst_o !== 1'b1 || loss_count_o !== 8'd0 || ready_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_abort: pll_rst=%b state=%0d sys_rst=%b loss=%0d ready=%b, required 0 0 1 0 0",
               pll_rst_o, state_o, sys_rst_o, loss_count_o, ready_o);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    locked_i = 1'b0;
    test_reset();
    test_release();
    test_settle_abort();
    test_glitch_and_loss();
    test_saturation();
    test_restart();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
